// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The IF/ID entry carries an abort marker that is only ever set when FETCH_ABORT_EN is defined.
package fetch_pkg;

    localparam int unsigned IF_XLEN     = 32;
    localparam int unsigned PC_STEP     = 4;
    localparam int unsigned PC_READ_OFS = 8;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [IF_XLEN-1:0] instr;
        logic [IF_XLEN-1:0] pc;
        logic [IF_XLEN-1:0] pc_plus8;
        logic               abort;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus and IF/ID handshake between fetch (master) and memory/decode (slave).
// The error/abort pair exists only when FETCH_ABORT_EN is defined.
interface fetch_stage_if #(
    parameter int unsigned XLEN = 32
);

    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_ready_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
`ifdef FETCH_ABORT_EN
    logic            imem_err_i;
    logic            if_abort_o;
`endif
    logic            if_valid_o;
    logic [XLEN-1:0] if_instr_o;
    logic [XLEN-1:0] if_pc_o;
    logic [XLEN-1:0] if_pc_plus8_o;
    logic            id_ready_i;

    modport master (
`ifdef FETCH_ABORT_EN
        input  imem_err_i,
        output if_abort_o,
`endif
        output imem_req_o,
        output imem_addr_o,
        input  imem_ready_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output if_valid_o,
        output if_instr_o,
        output if_pc_o,
        output if_pc_plus8_o,
        input  id_ready_i
    );

    modport slave (
`ifdef FETCH_ABORT_EN
        output imem_err_i,
        input  if_abort_o,
`endif
        input  imem_req_o,
        input  imem_addr_o,
        output imem_ready_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  if_valid_o,
        input  if_instr_o,
        input  if_pc_o,
        input  if_pc_plus8_o,
        output id_ready_i
    );

endinterface

// File: rtl/fetch_stage_if_id_buffer.sv
// Single-entry IF/ID buffer: flush beats load, load beats consume.
module if_id_buffer
    import fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   flush,
    input  logic   load,
    input  logic   consume,
    input  if_id_t load_data,
    output if_id_t entry
);

    // Clearing only valid/abort keeps the payload flops free of enable fan-in from flush/consume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry <= '0;
        end else if (flush) begin
            entry.valid <= 1'b0;
            entry.abort <= 1'b0;
        end else if (load) begin
            entry <= load_data;
        end else if (consume) begin
            entry.valid <= 1'b0;
            entry.abort <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the PC register, issues one imem request at a time,
// and fills the IF/ID buffer. Optional prefetch-abort support under FETCH_ABORT_EN.
module fetch_stage #(
    parameter int unsigned XLEN        = fetch_pkg::IF_XLEN,
    parameter int unsigned PC_STEP     = fetch_pkg::PC_STEP,
    parameter int unsigned PC_READ_OFS = fetch_pkg::PC_READ_OFS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_next_o,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_target_i,
    fetch_stage_if.master   bus
);

    import fetch_pkg::*;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] faddr_q;
    logic            req, accept, load, consume;
    if_id_t          load_data, buf_q;

    assign req     = (state_q == REQ) && (!buf_q.valid || bus.id_ready_i);
    assign accept  = req && bus.imem_ready_i;
    assign consume = buf_q.valid && bus.id_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            faddr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                faddr_q <= pc_i;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_next_o = pc_i;
        load      = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (accept) begin
                    state_d   = WAIT;
                    pc_next_o = pc_i + XLEN'(PC_STEP);
                end
            end
            WAIT: begin
                if (bus.imem_rvalid_i) begin
                    load    = 1'b1;
                    state_d = REQ;
                end
            end
            DROP: begin
                if (bus.imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_i) begin
            pc_next_o = redirect_target_i & ~XLEN'(3);
            load      = 1'b0;
            case (state_q)
                REQ:       state_d = accept ? DROP : REQ;
                WAIT, DROP: state_d = bus.imem_rvalid_i ? REQ : DROP;
                default:   state_d = REQ;
            endcase
        end
    end

    always_comb begin
        load_data          = '0;
        load_data.valid    = 1'b1;
        load_data.instr    = bus.imem_rdata_i;
        load_data.pc       = faddr_q;
        load_data.pc_plus8 = faddr_q + XLEN'(PC_READ_OFS);
`ifdef FETCH_ABORT_EN
        if (bus.imem_err_i) begin
            load_data.instr = '0;
            load_data.abort = 1'b1;
        end
`endif
    end

    if_id_buffer u_if_id_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_i),
        .load      (load),
        .consume   (consume),
        .load_data (load_data),
        .entry     (buf_q)
    );

    assign bus.imem_req_o    = req;
    assign bus.imem_addr_o   = pc_i;
    assign bus.if_valid_o    = buf_q.valid;
    assign bus.if_instr_o    = buf_q.instr;
    assign bus.if_pc_o       = buf_q.pc;
    assign bus.if_pc_plus8_o = buf_q.pc_plus8;
`ifdef FETCH_ABORT_EN
    assign bus.if_abort_o    = buf_q.abort;
`else
    logic unused_abort;
    assign unused_abort = buf_q.abort;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with a PC register and latency-configurable imem model.
// Abort checks are compiled in only when FETCH_ABORT_EN is defined.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] target;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          lat;
    int          cnt;
    logic [31:0] paddr;
    logic        err_en;

    fetch_stage_if #(.XLEN(32)) bus ();

    fetch_stage #(.XLEN(32), .PC_STEP(4), .PC_READ_OFS(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_i              (pc),
        .pc_next_o         (pc_next),
        .redirect_i        (redirect),
        .redirect_target_i (target),
        .bus               (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // PC register loaded every cycle from the fetch stage.
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= '0;
        else     pc <= pc_next;
    end

    // Instruction memory: response 'lat' cycles after acceptance, data = 0xE0000000 | addr.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt               <= 0;
            paddr             <= '0;
            bus.imem_rvalid_i <= 1'b0;
            bus.imem_rdata_i  <= '0;
`ifdef FETCH_ABORT_EN
            bus.imem_err_i    <= 1'b0;
`endif
        end else begin
            bus.imem_rvalid_i <= 1'b0;
            if (bus.imem_req_o && bus.imem_ready_i) begin
                paddr <= bus.imem_addr_o;
                if (lat == 1) begin
                    bus.imem_rvalid_i <= 1'b1;
                    bus.imem_rdata_i  <= 32'hE000_0000 | bus.imem_addr_o;
`ifdef FETCH_ABORT_EN
                    bus.imem_err_i    <= err_en && (bus.imem_addr_o == 32'h40);
`endif
                    cnt <= 0;
                end else begin
                    cnt <= lat - 1;
                end
            end else if (cnt != 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    bus.imem_rvalid_i <= 1'b1;
                    bus.imem_rdata_i  <= 32'hE000_0000 | paddr;
`ifdef FETCH_ABORT_EN
                    bus.imem_err_i    <= err_en && (paddr == 32'h40);
`endif
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst              = 1'b1;
        redirect         = 1'b0;
        target           = '0;
        bus.imem_ready_i = 1'b1;
        bus.id_ready_i   = 1'b1;
        lat              = 1;
        err_en           = 1'b0;
        cyc();
        cyc();
        chk("rst_valid", 32'(bus.if_valid_o), 32'h0);
        chk("rst_instr", bus.if_instr_o, 32'h0);
        chk("rst_pc", bus.if_pc_o, 32'h0);
        chk("rst_plus8", bus.if_pc_plus8_o, 32'h0);
        chk("rst_req", 32'(bus.imem_req_o), 32'h0);
        chk("rst_pcnext", pc_next, 32'h0);
`ifdef FETCH_ABORT_EN
        chk("rst_abort", 32'(bus.if_abort_o), 32'h0);
`endif
        rst = 1'b0;

        // Sequential stream 0x0, 0x4, 0x8
        cyc();
        chk("seq_req0", 32'(bus.imem_req_o), 32'h1);
        chk("seq_addr0", bus.imem_addr_o, 32'h0);
        chk("seq_pcnext0", pc_next, 32'h4);
        cyc();
        chk("wait_req", 32'(bus.imem_req_o), 32'h0);
        chk("wait_pcnext", pc_next, 32'h4);
        chk("wait_valid", 32'(bus.if_valid_o), 32'h0);
        cyc();
        chk("ld0_valid", 32'(bus.if_valid_o), 32'h1);
        chk("ld0_instr", bus.if_instr_o, 32'hE000_0000);
        chk("ld0_pc", bus.if_pc_o, 32'h0);
        chk("ld0_plus8", bus.if_pc_plus8_o, 32'h8);
        chk("seq_addr4", bus.imem_addr_o, 32'h4);
        chk("seq_pcnext4", pc_next, 32'h8);
        cyc();
        chk("consume_valid", 32'(bus.if_valid_o), 32'h0);
        cyc();
        chk("ld4_valid", 32'(bus.if_valid_o), 32'h1);
        chk("ld4_pc", bus.if_pc_o, 32'h4);
        chk("ld4_plus8", bus.if_pc_plus8_o, 32'hC);
        chk("ld4_instr", bus.if_instr_o, 32'hE000_0004);
        chk("seq_addr8", bus.imem_addr_o, 32'h8);
        cyc();
        cyc();
        chk("ld8_pc", bus.if_pc_o, 32'h8);
        chk("ld8_plus8", bus.if_pc_plus8_o, 32'h10);
        chk("ld8_instr", bus.if_instr_o, 32'hE000_0008);
        chk("seq_pcnextC", pc_next, 32'h10);

        // Decode stall with full buffer
        bus.id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_req", 32'(bus.imem_req_o), 32'h0);
            chk("stall_pc", pc, 32'hC);
            chk("stall_instr", bus.if_instr_o, 32'hE000_0008);
            chk("stall_valid", 32'(bus.if_valid_o), 32'h1);
        end
        bus.id_ready_i = 1'b1;
        lat = 2;
        #1;
        chk("resume_req", 32'(bus.imem_req_o), 32'h1);
        chk("resume_addr", bus.imem_addr_o, 32'hC);

        // Redirect while waiting on a response
        cyc();
        chk("rw_valid", 32'(bus.if_valid_o), 32'h0);
        chk("rw_req", 32'(bus.imem_req_o), 32'h0);
        redirect = 1'b1;
        target   = 32'h103;
        #1;
        chk("rw_pcnext", pc_next, 32'h100);
        cyc();
        redirect = 1'b0;
        #1;
        chk("drop_req", 32'(bus.imem_req_o), 32'h0);
        chk("drop_valid", 32'(bus.if_valid_o), 32'h0);
        chk("drop_pcnext", pc_next, 32'h100);
        lat = 1;
        cyc();
        chk("rw_stale_valid", 32'(bus.if_valid_o), 32'h0);
        chk("rw_req2", 32'(bus.imem_req_o), 32'h1);
        chk("rw_addr", bus.imem_addr_o, 32'h100);
        cyc();
        chk("rw_wait_valid", 32'(bus.if_valid_o), 32'h0);
        cyc();
        chk("rw_ld_valid", 32'(bus.if_valid_o), 32'h1);
        chk("rw_ld_instr", bus.if_instr_o, 32'hE000_0100);
        chk("rw_ld_pc", bus.if_pc_o, 32'h100);
        chk("rw_ld_plus8", bus.if_pc_plus8_o, 32'h108);

        // Redirect without acceptance flushes even with decode stalled
        bus.imem_ready_i = 1'b0;
        bus.id_ready_i   = 1'b0;
        redirect         = 1'b1;
        target           = 32'h20;
        #1;
        chk("rr_pcnext", pc_next, 32'h20);
        cyc();
        chk("rr_flush_valid", 32'(bus.if_valid_o), 32'h0);

        // Redirect in the same cycle as an accepted request at 0x20
        bus.imem_ready_i = 1'b1;
        bus.id_ready_i   = 1'b1;
        target           = 32'h200;
        #1;
        chk("ra_addr", bus.imem_addr_o, 32'h20);
        chk("ra_req", 32'(bus.imem_req_o), 32'h1);
        chk("ra_pcnext", pc_next, 32'h200);
        cyc();
        redirect = 1'b0;
        #1;
        chk("ra_drop_req", 32'(bus.imem_req_o), 32'h0);
        chk("ra_pcnext2", pc_next, 32'h200);
        cyc();
        chk("ra_stale_valid", 32'(bus.if_valid_o), 32'h0);
        chk("ra_req2", 32'(bus.imem_req_o), 32'h1);
        chk("ra_addr2", bus.imem_addr_o, 32'h200);
        cyc();
        cyc();
        chk("ra_ld_valid", 32'(bus.if_valid_o), 32'h1);
        chk("ra_ld_pc", bus.if_pc_o, 32'h200);
        chk("ra_ld_instr", bus.if_instr_o, 32'hE000_0200);

        // Unaligned target and address wrap at the top of memory
        bus.imem_ready_i = 1'b0;
        redirect         = 1'b1;
        target           = 32'hFFFF_FFFF;
        #1;
        chk("wrap_align", pc_next, 32'hFFFF_FFFC);
        cyc();
        bus.imem_ready_i = 1'b1;
        redirect         = 1'b0;
        #1;
        chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
        chk("wrap_pcnext", pc_next, 32'h0);
        chk("wrap_valid", 32'(bus.if_valid_o), 32'h0);
        cyc();
        cyc();
        chk("wrap_pc", bus.if_pc_o, 32'hFFFF_FFFC);
        chk("wrap_plus8", bus.if_pc_plus8_o, 32'h4);
        chk("wrap_instr", bus.if_instr_o, 32'hFFFF_FFFC);
        chk("wrap_nextaddr", bus.imem_addr_o, 32'h0);

`ifdef FETCH_ABORT_EN
        // Error response at 0x40 becomes a prefetch-abort marker
        bus.imem_ready_i = 1'b0;
        redirect         = 1'b1;
        target           = 32'h40;
        cyc();
        bus.imem_ready_i = 1'b1;
        redirect         = 1'b0;
        err_en           = 1'b1;
        #1;
        chk("ab_addr", bus.imem_addr_o, 32'h40);
        cyc();
        cyc();
        chk("ab_valid", 32'(bus.if_valid_o), 32'h1);
        chk("ab_abort", 32'(bus.if_abort_o), 32'h1);
        chk("ab_instr", bus.if_instr_o, 32'h0);
        chk("ab_pc", bus.if_pc_o, 32'h40);
        err_en = 1'b0;
`endif

        // Asynchronous reset in the middle of WAIT
        lat = 3;
        cyc();
        chk("mr_req", 32'(bus.imem_req_o), 32'h0);
        chk("mr_valid", 32'(bus.if_valid_o), 32'h0);
`ifdef FETCH_ABORT_EN
        chk("ab_clear", 32'(bus.if_abort_o), 32'h0);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("mr_instr", bus.if_instr_o, 32'h0);
        chk("mr_pc", bus.if_pc_o, 32'h0);
        chk("mr_plus8", bus.if_pc_plus8_o, 32'h0);
        chk("mr_req2", 32'(bus.imem_req_o), 32'h0);
        chk("mr_pcnext", pc_next, 32'h0);
`ifdef FETCH_ABORT_EN
        chk("mr_abort", 32'(bus.if_abort_o), 32'h0);
`endif
        cyc();
        rst = 1'b0;
        lat = 1;
        cyc();
        chk("mr_restart_req", 32'(bus.imem_req_o), 32'h1);
        chk("mr_restart_addr", bus.imem_addr_o, 32'h0);
        chk("mr_restart_valid", 32'(bus.if_valid_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
